// File: rtl/mult_pkg.sv
// Shared constants and the converter state encoding for the multiplier display path.
package mult_pkg;
  localparam int PROD_W     = 16;
  localparam int BCD_DIGITS = 5;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: bump a BCD digit by 3 when it would overflow after the shift.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] fixed
);
  assign fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/product_bcd.sv
// Signed product to sign + packed BCD, one magnitude bit per clock (shift-add-3).
module product_bcd
  import mult_pkg::*;
#(
  parameter int WIDTH  = PROD_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  Clk,
  input  logic                  Reset_L,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Product,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Neg,
  output logic [4*DIGITS-1:0]   BCD
);
  localparam int CW = $clog2(WIDTH);
  localparam int BW = 4*DIGITS;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    scratch, fixed, scratch_nxt;
  logic             neg_lat;
  logic             last;
  logic             unused_msb;

  assign last = (cnt == CW'(WIDTH-1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (.digit(scratch[4*g +: 4]), .fixed(fixed[4*g +: 4]));
  end

  // The top digit's MSB is shifted out; range guarantees it is always zero.
  assign scratch_nxt = {fixed[BW-2:0], mag[WIDTH-1]};
  assign unused_msb  = fixed[BW-1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = CONV;
      CONV:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      cnt     <= '0;
      mag     <= '0;
      scratch <= '0;
      neg_lat <= 1'b0;
      Neg     <= 1'b0;
      BCD     <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Busy <= (state_nxt == CONV);
      Done <= (state_nxt == DONE);
      case (state)
        IDLE: if (Start) begin
          neg_lat <= Product[WIDTH-1];
          mag     <= Product[WIDTH-1] ? (~Product + WIDTH'(1)) : Product;
          scratch <= '0;
          cnt     <= '0;
        end
        CONV: begin
          scratch <= scratch_nxt;
          mag     <= mag << 1;
          cnt     <= cnt + CW'(1);
          if (last) begin
            BCD <= scratch_nxt;
            Neg <= neg_lat;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_product_bcd.sv
// Scoreboarded bench for product_bcd: expected results queued at Start, checked on every Done.
module tb_product_bcd;
  logic        Clk = 1'b0;
  logic        Reset_L;
  logic        Start;
  logic [15:0] Product;
  logic        Busy, Done, Neg;
  logic [19:0] BCD;

  typedef struct { logic [19:0] bcd; logic neg; } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;

  product_bcd #(.WIDTH(16), .DIGITS(5)) dut (
    .Clk(Clk), .Reset_L(Reset_L), .Start(Start), .Product(Product),
    .Busy(Busy), .Done(Done), .Neg(Neg), .BCD(BCD)
  );

  always #5 Clk = ~Clk;

  function automatic exp_t model(input logic [15:0] p);
    exp_t e;
    int m;
    m = p[15] ? 65536 - int'(p) : int'(p);
    e.neg = p[15];
    e.bcd = '0;
    for (int i = 0; i < 5; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return e;
  endfunction

  // Scoreboard: every Done pulse must match the oldest outstanding request.
  always @(negedge Clk) begin
    if (Reset_L === 1'b1 && Done === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: Done=1 with nothing outstanding, BCD=%h Neg=%b", BCD, Neg);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (BCD !== e.bcd || Neg !== e.neg) begin
          fails++;
          $display("FAIL scoreboard: got BCD=%h Neg=%b, expected BCD=%h Neg=%b", BCD, Neg, e.bcd, e.neg);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((Busy !== 1'b0 || Done !== 1'b0) && n < 60) begin
      @(posedge Clk); #1;
      n++;
    end
    tests++;
    if (n >= 60) begin
      fails++;
      $display("FAIL idle_timeout: Busy=%b Done=%b, expected both 0", Busy, Done);
    end
  endtask

  task automatic run_conv(input logic [15:0] p);
    bit seen;
    wait_idle();
    @(negedge Clk);
    Product = p;
    Start   = 1'b1;
    q.push_back(model(p));
    @(posedge Clk); #1;
    Start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      if (Done === 1'b1) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout: product=%h Done never asserted", p);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Reset_L = 1'b0; Start = 1'b0; Product = '0;
    #1;
    tests++;
    if ({Busy, Done, Neg, BCD} !== 23'd0) begin
      fails++;
      $display("FAIL reset_state: Busy=%b Done=%b Neg=%b BCD=%h, expected 0/0/0/00000", Busy, Done, Neg, BCD);
    end
    repeat (2) @(negedge Clk);
    Reset_L = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_positive();
    wait_idle();
    @(negedge Clk);
    Product = 16'h0051;
    Start   = 1'b1;
    q.push_back(model(16'h0051));
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge Clk); #1;
      tests++;
      if (Done !== (k == 16)) begin
        fails++;
        $display("FAIL done_timing: edge +%0d Done=%b, expected %b", k, Done, (k == 16));
      end
      tests++;
      if (Busy !== (k < 16)) begin
        fails++;
        $display("FAIL busy_timing: edge +%0d Busy=%b, expected %b", k, Busy, (k < 16));
      end
      if (k == 16) begin
        tests++;
        if (BCD !== 20'h00081 || Neg !== 1'b0) begin
          fails++;
          $display("FAIL positive_81: BCD=%h Neg=%b, expected 00081/0", BCD, Neg);
        end
      end
    end
  endtask

  task automatic test_extremes();
    run_conv(16'hC080);
    tests++;
    if (BCD !== 20'h16256 || Neg !== 1'b1) begin
      fails++;
      $display("FAIL neg_c080: BCD=%h Neg=%b, expected 16256/1", BCD, Neg);
    end
    run_conv(16'h4000);
    tests++;
    if (BCD !== 20'h16384 || Neg !== 1'b0) begin
      fails++;
      $display("FAIL pos_4000: BCD=%h Neg=%b, expected 16384/0", BCD, Neg);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] p[3];
    logic [19:0] b[3];
    logic        n[3];
    p = '{16'h0000, 16'h8000, 16'h7FFF};
    b = '{20'h00000, 20'h32768, 20'h32767};
    n = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_conv(p[i]);
      tests++;
      if (BCD !== b[i] || Neg !== n[i]) begin
        fails++;
        $display("FAIL boundary_%h: BCD=%h Neg=%b, expected %h/%b", p[i], BCD, Neg, b[i], n[i]);
      end
    end
    // A few random values through the scoreboard.
    for (int i = 0; i < 4; i++) run_conv(16'($urandom));
  endtask

  task automatic test_back_to_back();
    int n;
    wait_idle();
    @(negedge Clk);
    Product = 16'h0051;
    Start   = 1'b1;
    // Held Start is accepted at edges 1, 19 and 37.
    q.push_back(model(16'h0051));
    q.push_back(model(16'hFFFF));
    q.push_back(model(16'hFFFF));
    for (int e = 1; e <= 40; e++) begin
      @(posedge Clk); #1;
      if (e == 5) Product = 16'hFFFF;
      if (e == 40) Start = 1'b0;
      if (e == 17) begin
        tests++;
        if (Done !== 1'b1 || BCD !== 20'h00081 || Neg !== 1'b0) begin
          fails++;
          $display("FAIL held_first: Done=%b BCD=%h Neg=%b, expected 1/00081/0", Done, BCD, Neg);
        end
      end
      if (e == 18) begin
        tests++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
          fails++;
          $display("FAIL held_done_ignored: Busy=%b Done=%b, expected 0/0", Busy, Done);
        end
      end
      if (e == 19) begin
        tests++;
        if (Busy !== 1'b1) begin
          fails++;
          $display("FAIL held_reaccept: Busy=%b, expected 1", Busy);
        end
      end
      if (e == 35) begin
        tests++;
        if (Done !== 1'b1 || BCD !== 20'h00001 || Neg !== 1'b1) begin
          fails++;
          $display("FAIL held_second: Done=%b BCD=%h Neg=%b, expected 1/00001/1", Done, BCD, Neg);
        end
      end
    end
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge Clk); #1;
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL held_drain: %0d results outstanding, expected 0", q.size());
    end
  endtask

  task automatic test_reset_after_result();
    run_conv(16'h7FFF);
    @(posedge Clk);
    #3 Reset_L = 1'b0;
    #1;
    tests++;
    if ({Busy, Done, Neg, BCD} !== 23'd0) begin
      fails++;
      $display("FAIL reset_after_result: Busy=%b Done=%b Neg=%b BCD=%h, expected all 0", Busy, Done, Neg, BCD);
    end
    @(negedge Clk);
    Reset_L = 1'b1;
  endtask

  task automatic test_reset_mid_conv();
    run_conv(16'h4000);
    wait_idle();
    @(negedge Clk);
    Product = 16'hC080;
    Start   = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (8) @(posedge Clk);
    #2 Reset_L = 1'b0;
    #1;
    tests++;
    if ({Busy, Done, Neg, BCD} !== 23'd0) begin
      fails++;
      $display("FAIL reset_mid_conv: Busy=%b Done=%b Neg=%b BCD=%h, expected all 0", Busy, Done, Neg, BCD);
    end
    repeat (2) @(negedge Clk);
    Reset_L = 1'b1;
    repeat (25) @(posedge Clk);
    #1;
    tests++;
    if (BCD !== 20'h00000 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL discarded_conv: BCD=%h Busy=%b, expected 00000/0", BCD, Busy);
    end
    run_conv(16'hC080);
    tests++;
    if (BCD !== 20'h16256 || Neg !== 1'b1) begin
      fails++;
      $display("FAIL after_reset_conv: BCD=%h Neg=%b, expected 16256/1", BCD, Neg);
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_extremes();
    test_boundaries();
    test_back_to_back();
    test_reset_after_result();
    test_reset_mid_conv();
    repeat (3) @(posedge Clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL final_queue: %0d results outstanding, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
